// File: rtl/pwm_mod_pkg.sv
// Shared types and constants for the PWM / PDM modulator.
package pwm_mod_pkg;

    // Fixed widths: 8-bit duty, 4-bit prescaler, 256-tick period.
    localparam int          DUTY_W   = 8;
    localparam int          DIV_W    = 4;
    localparam logic [7:0]  PRD_LAST = 8'd255;

    // Modulator control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_STOP  = 2'd3
    } pwm_state_e;

    // The prescaler and period counter advance only in these states.
    function automatic logic is_counting(input pwm_state_e s);
        return (s == ST_RUN) || (s == ST_STOP);
    endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Prescaler plus period counter: one tick every pwm_div+1 clocks while
// counting, and an 8-bit period position that advances on each tick.
module pwm_tick_gen
    import pwm_mod_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              cnt_en,
    input  logic              cnt_clr,
    input  logic [DIV_W-1:0]  pwm_div,
    output logic              tick,
    output logic [DUTY_W-1:0] prd_cnt,
    output logic              prd_last
);

    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [DUTY_W-1:0] prd_cnt_q, prd_cnt_d;

    // Next-count logic. A divider shrunk below the current count is not
    // special-cased: div_cnt keeps incrementing, wraps through 15 and
    // ticks when it next equals pwm_div.
    always_comb begin
        tick      = cnt_en && (div_cnt_q == pwm_div);
        div_cnt_d = div_cnt_q;
        prd_cnt_d = prd_cnt_q;
        if (cnt_clr) begin
            div_cnt_d = '0;
            prd_cnt_d = '0;
        end else if (cnt_en) begin
            if (tick) begin
                div_cnt_d = '0;
                prd_cnt_d = prd_cnt_q + 8'd1;
            end else begin
                div_cnt_d = div_cnt_q + 4'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q <= '0;
            prd_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            prd_cnt_q <= prd_cnt_d;
        end
    end

    assign prd_cnt  = prd_cnt_q;
    assign prd_last = tick && (prd_cnt_q == PRD_LAST);

endmodule

// File: rtl/pwm_mod.sv
// PWM / first-order sigma-delta modulator driving the AGC analog filter.
// New duty values are double-buffered and only take effect at a period
// boundary (or at START), so each period is generated with one duty.
//
// Update strobe: pwm_val is sampled in the single cycle pwm_val_up is
// high; there is no back-pressure, a later strobe overwrites the shadow.
module pwm_mod
    import pwm_mod_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              pwm_ena,
    input  logic              pwm_inv,
    input  logic [DUTY_W-1:0] pwm_val,
    input  logic              pwm_val_up,
    input  logic [DIV_W-1:0]  pwm_div,
    input  logic              pwm_mode,
    output logic              pwm_out,
    output logic [DUTY_W-1:0] pwm_cur,
    output logic              pwm_prd_end,
    output logic              pwm_upd_ack,
    output logic              pwm_run
);

    pwm_state_e        state_q, state_d;
    logic [DUTY_W-1:0] shadow_q, shadow_d;
    logic              pending_q, pending_d;
    logic [DUTY_W-1:0] active_q, active_d;
    logic              mode_q, mode_d;
    logic [DUTY_W-1:0] acc_q, acc_d;
    logic              out_q, out_d;
    logic              prd_last_q, prd_last_d;
    logic              prd_end_q, prd_end_d;
    logic              ack_q, ack_d;

    logic              counting;
    logic              tick;
    logic [DUTY_W-1:0] prd_cnt;
    logic              prd_last;
    logic              period_load;
    logic              do_load;
    logic [DUTY_W:0]   sum;
    logic              raw;

    assign counting = is_counting(state_q);

    pwm_tick_gen u_tick_gen (
        .clk      (clk),
        .reset    (reset),
        .cnt_en   (counting),
        .cnt_clr  (!counting),
        .pwm_div  (pwm_div),
        .tick     (tick),
        .prd_cnt  (prd_cnt),
        .prd_last (prd_last)
    );

    // Control, duty buffering and waveform generation.
    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        pending_d  = pending_q;
        active_d   = active_q;
        mode_d     = mode_q;
        acc_d      = acc_q;

        // A period end only counts as a load point if modulation continues
        // into the next period (RUN, or STOP being re-enabled right there).
        period_load = prd_last && ((state_q == ST_RUN) || pwm_ena);
        do_load     = (state_q == ST_START) ||
                      (period_load && (pending_q || pwm_val_up));

        if (pwm_val_up) begin
            shadow_d  = pwm_val;
            pending_d = 1'b1;
        end

        // A strobe in the load cycle itself bypasses the shadow.
        if (do_load) begin
            active_d  = pwm_val_up ? pwm_val : shadow_q;
            pending_d = 1'b0;
        end

        if ((state_q == ST_START) || period_load) begin
            mode_d = pwm_mode;
        end

        // Sigma-delta: the carry of acc+active is the bit for the current
        // tick; the sum is committed when the tick completes.
        sum = {1'b0, acc_q} + {1'b0, active_q};
        if (state_q == ST_START) begin
            acc_d = '0;
        end else if (tick && mode_q) begin
            acc_d = sum[DUTY_W-1:0];
        end

        if (!counting) begin
            raw = 1'b0;
        end else if (mode_q) begin
            raw = sum[DUTY_W];
        end else begin
            raw = (prd_cnt < active_q);
        end

        out_d      = raw ^ pwm_inv;
        ack_d      = do_load;
        // Two stages so the pulse lines up with the first output cycle of
        // the new period (the output itself lags the counter by one).
        prd_last_d = prd_last;
        prd_end_d  = prd_last_q;

        case (state_q)
            ST_IDLE:  if (pwm_ena) state_d = ST_START;
            ST_START: state_d = ST_RUN;
            ST_RUN:   if (!pwm_ena) state_d = ST_STOP;
            ST_STOP: begin
                if (pwm_ena) begin
                    state_d = ST_RUN;
                end else if (prd_last) begin
                    state_d = ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // All state and output registers; reset aborts and drops pending duty.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            shadow_q   <= '0;
            pending_q  <= 1'b0;
            active_q   <= '0;
            mode_q     <= 1'b0;
            acc_q      <= '0;
            out_q      <= 1'b0;
            prd_last_q <= 1'b0;
            prd_end_q  <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            pending_q  <= pending_d;
            active_q   <= active_d;
            mode_q     <= mode_d;
            acc_q      <= acc_d;
            out_q      <= out_d;
            prd_last_q <= prd_last_d;
            prd_end_q  <= prd_end_d;
            ack_q      <= ack_d;
        end
    end

    assign pwm_out     = out_q;
    assign pwm_cur     = active_q;
    assign pwm_prd_end = prd_end_q;
    assign pwm_upd_ack = ack_q;
    assign pwm_run     = (state_q != ST_IDLE);

endmodule
